// File: rtl/barrel_shifter_pipe.sv
// -----------------------------------------------------------------------------
// barrel_shifter_pipe
//
// Pipelined barrel shifter with four shift modes and valid/ready handshakes on
// both sides. An input capture register latches the accepted request. It is
// followed by SHW = log2(WIDTH) shift stages. Stage k shifts by 2^k when bit k
// of the carried amount is set, and registers its result. A new request can be
// accepted every clock, and a result appears SHW cycles after acceptance when
// the pipeline is not stalled.
//
// The pipeline uses a global stall. When the output holds a result that the
// consumer is not taking, every stage holds, and bubbles are not squeezed out.
//
// Parameters
//   WIDTH      data width; must be a power of two and at least 2
//   SHW        log2(WIDTH), shift-amount width and shift-stage count (derived)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request present on in_data / in_amt / in_mode
//   in_ready   block accepts a request this cycle (= pipeline advance)
//   in_data    operand
//   in_amt     shift amount, 0..WIDTH-1
//   in_mode    00 LSR, 01 LSL, 10 ASR, 11 ROR
//   out_valid  result present on out_data / out_zero
//   out_ready  consumer accepts the result this cycle
//   out_data   shifted result
//   out_zero   high when out_data is all zeros
// -----------------------------------------------------------------------------
module barrel_shifter_pipe #(
    parameter  int WIDTH = 8,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    localparam logic [1:0] MODE_LSR = 2'b00;
    localparam logic [1:0] MODE_LSL = 2'b01;
    localparam logic [1:0] MODE_ASR = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    // Shift by exactly 2^k in the requested mode. Because k < SHW, the shift
    // distance is always less than WIDTH, so the complementary shifts used for
    // the fill and the rotate are always in range.
    function automatic logic [WIDTH-1:0] shift_pow2(
        input logic [WIDTH-1:0] d,
        input logic [1:0]       mode,
        input logic             sign,
        input int               k
    );
        int               sh;
        logic [WIDTH-1:0] fill;
        sh   = 1 << k;
        fill = {WIDTH{sign}} << (WIDTH - sh);
        case (mode)
            MODE_LSR: shift_pow2 = d >> sh;
            MODE_LSL: shift_pow2 = d << sh;
            MODE_ASR: shift_pow2 = (d >> sh) | fill;
            MODE_ROR: shift_pow2 = (d >> sh) | (d << (WIDTH - sh));
            default:  shift_pow2 = d;
        endcase
    endfunction

    // Index 0 is the capture register. Index k+1 holds the output of shift
    // stage k, so index SHW drives the block outputs. The amount, mode and sign
    // are needed only as inputs to the shift stages, so their arrays stop at
    // SHW-1.
    logic             vld_p  [SHW+1];
    logic [WIDTH-1:0] data_p [SHW+1];
    logic [SHW-1:0]   amt_p  [SHW];
    logic [1:0]       mode_p [SHW];
    logic             sign_p [SHW];
    logic             zero_p;

    logic [WIDTH-1:0] shifted [SHW];
    logic             zero_next;
    logic             advance;

    assign out_valid = vld_p[SHW];
    assign out_data  = data_p[SHW];
    assign out_zero  = zero_p;

    // A single stall signal for the whole pipeline. in_ready therefore depends
    // combinationally on out_ready, but never on any in_* signal.
    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance;

    // Combinational shift for each stage. Each stage examines only its own
    // amount bit.
    always_comb begin
        for (int k = 0; k < SHW; k++) begin
            shifted[k] = amt_p[k][k] ? shift_pow2(data_p[k], mode_p[k], sign_p[k], k)
                                     : data_p[k];
        end
        zero_next = (shifted[SHW-1] == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= SHW; k++) begin
                vld_p[k]  <= 1'b0;
                data_p[k] <= '0;
            end
            for (int k = 0; k < SHW; k++) begin
                amt_p[k]  <= '0;
                mode_p[k] <= '0;
                sign_p[k] <= 1'b0;
            end
            zero_p <= 1'b0;
        end else if (advance) begin
            // ---- capture: latch the accepted request and its sign bit ----
            // When advance is 1, in_ready is also 1, so in_valid alone marks a transfer.
            vld_p[0]  <= in_valid;
            data_p[0] <= in_data;
            amt_p[0]  <= in_amt;
            mode_p[0] <= in_mode;
            sign_p[0] <= in_data[WIDTH-1];
            // ---- shift stages: stage k result into register k+1 ----
            for (int k = 0; k < SHW; k++) begin
                vld_p[k+1]  <= vld_p[k];
                data_p[k+1] <= shifted[k];
            end
            for (int k = 1; k < SHW; k++) begin
                amt_p[k]  <= amt_p[k-1];
                mode_p[k] <= mode_p[k-1];
                sign_p[k] <= sign_p[k-1];
            end
            // ---- output: zero flag registered with the final data ----
            zero_p <= zero_next;
        end
    end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// -----------------------------------------------------------------------------
// tb_barrel_shifter_pipe
//
// Directed testbench for barrel_shifter_pipe with WIDTH = 8. Every scenario
// drives a fixed timeline. Expected results come from hand-computed tables or
// from a whole-word reference model.
// -----------------------------------------------------------------------------
module tb_barrel_shifter_pipe;

    localparam int W = 8;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic [2:0]   in_amt = '0;
    logic [1:0]   in_mode = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_data;
    logic         out_zero;

    int tests = 0;
    int fails = 0;

    barrel_shifter_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    // Whole-word reference: the complete shift is applied in one step.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [2:0] a,
                                               input logic [1:0] m);
        logic [2*W-1:0] dd;
        logic [W-1:0]   r;
        case (m)
            2'd0: r = d >> a;
            2'd1: r = d << a;
            2'd2: r = W'($signed(d) >>> a);
            default: begin
                dd = {d, d} >> a;
                r  = dd[W-1:0];
            end
        endcase
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_out_data: got %h want 00", out_data); end
        tests++; if (out_zero !== 1'b0) begin fails++; $display("FAIL reset_out_zero: got %b want 0", out_zero); end
        rst_n = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_modes;
        logic [1:0] vm [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [7:0] ve [4] = '{8'h16, 8'hA0, 8'hF6, 8'h96};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 8'hB4; in_amt = 3'd3; in_mode = vm[i];
            tick;
            in_valid = 1'b0;
            for (int s = 0; s < LAT; s++) begin
                tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mode%0d_early_valid: cycle %0d got %b want 0", i, s, out_valid); end
                tick;
            end
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mode%0d_valid: got %b want 1", i, out_valid); end
            tests++; if (out_data !== ve[i]) begin fails++; $display("FAIL mode%0d_data: got %h want %h", i, out_data, ve[i]); end
            tests++; if (out_zero !== 1'b0) begin fails++; $display("FAIL mode%0d_zero: got %b want 0", i, out_zero); end
            tick;
        end
    endtask

    task automatic test_boundaries;
        logic [7:0] bd [8] = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'h80, 8'h80, 8'h01, 8'h01};
        logic [2:0] ba [8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7, 3'd1};
        logic [1:0] bm [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd1, 2'd0};
        logic [7:0] be [8] = '{8'h5A, 8'h5A, 8'h5A, 8'h5A, 8'hFF, 8'h01, 8'h80, 8'h00};
        logic       bz [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_data = bd[i]; in_amt = ba[i]; in_mode = bm[i];
            tick;
            in_valid = 1'b0;
            repeat (LAT) tick;
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bound%0d_valid: got %b want 1", i, out_valid); end
            tests++; if (out_data !== be[i]) begin fails++; $display("FAIL bound%0d_data: got %h want %h", i, out_data, be[i]); end
            tests++; if (out_zero !== bz[i]) begin fails++; $display("FAIL bound%0d_zero: got %b want %b", i, out_zero, bz[i]); end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] sd [16];
        logic [2:0] sa [16];
        logic [1:0] sm [16];
        logic [7:0] exp_d;
        bit         expv;
        for (int i = 0; i < 16; i++) begin
            sd[i] = 8'($urandom);
            sa[i] = 3'($urandom);
            sm[i] = 2'($urandom);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c < 16) begin
                in_valid = 1'b1; in_data = sd[c]; in_amt = sa[c]; in_mode = sm[c];
            end else begin
                in_valid = 1'b0;
            end
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_in_ready c%0d: got %b want 1", c, in_ready); end
            tick;
            if (c >= LAT) begin
                expv = (c - LAT) < 16;
                tests++; if (out_valid !== expv) begin fails++; $display("FAIL stream_valid c%0d: got %b want %b", c, out_valid, expv); end
                if (expv) begin
                    exp_d = ref_shift(sd[c-LAT], sa[c-LAT], sm[c-LAT]);
                    tests++; if (out_data !== exp_d) begin fails++; $display("FAIL stream_data r%0d: got %h want %h", c - LAT, out_data, exp_d); end
                    tests++; if (out_zero !== (exp_d == 8'h00)) begin fails++; $display("FAIL stream_zero r%0d: got %b want %b", c - LAT, out_zero, exp_d == 8'h00); end
                end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [7:0] pd [5] = '{8'hC3, 8'h81, 8'h7E, 8'hF0, 8'h11};
        logic [2:0] pa [5] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        logic [1:0] pm [5] = '{2'd2, 2'd3, 2'd1, 2'd0, 2'd3};
        logic [7:0] pe [5];
        for (int i = 0; i < 5; i++) pe[i] = ref_shift(pd[i], pa[i], pm[i]);
        out_ready = 1'b0;
        // Four requests fill the capture register and the three shift stages.
        for (int c = 0; c < 4; c++) begin
            in_valid = 1'b1; in_data = pd[c]; in_amt = pa[c]; in_mode = pm[c];
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_fill_ready c%0d: got %b want 1", c, in_ready); end
            tick;
        end
        in_data = pd[4]; in_amt = pa[4]; in_mode = pm[4];
        for (int s = 0; s < 4; s++) begin
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_stall_ready s%0d: got %b want 0", s, in_ready); end
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_stall_valid s%0d: got %b want 1", s, out_valid); end
            tests++; if (out_data !== pe[0]) begin fails++; $display("FAIL bp_stall_data s%0d: got %h want %h", s, out_data, pe[0]); end
            tick;
        end
        out_ready = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        tick;
        in_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_drain_valid r%0d: got %b want 1", i, out_valid); end
            tests++; if (out_data !== pe[i]) begin fails++; $display("FAIL bp_drain_data r%0d: got %h want %h", i, out_data, pe[i]); end
            tick;
        end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty_valid: got %b want 0", out_valid); end
    endtask

    task automatic test_bubbles;
        logic [7:0] bd [4] = '{8'h96, 8'h3C, 8'hE1, 8'h08};
        logic [2:0] ba [4] = '{3'd2, 3'd5, 3'd6, 3'd3};
        logic [1:0] bm [4] = '{2'd3, 2'd1, 2'd2, 2'd0};
        logic [7:0] exp_d;
        bit         expv;
        int         k;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            if (c < 8 && (c % 2) == 0) begin
                in_valid = 1'b1; in_data = bd[c/2]; in_amt = ba[c/2]; in_mode = bm[c/2];
            end else begin
                in_valid = 1'b0;
            end
            tick;
            if (c >= LAT) begin
                k = c - LAT;
                expv = (k < 8) && ((k % 2) == 0);
                tests++; if (out_valid !== expv) begin fails++; $display("FAIL bubble_valid c%0d: got %b want %b", c, out_valid, expv); end
                if (expv) begin
                    exp_d = ref_shift(bd[k/2], ba[k/2], bm[k/2]);
                    tests++; if (out_data !== exp_d) begin fails++; $display("FAIL bubble_data r%0d: got %h want %h", k / 2, out_data, exp_d); end
                end
            end
        end
    endtask

    task automatic test_reset_midflight;
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'hFF; in_amt = 3'd0; in_mode = 2'd0;
        tick;
        in_data = 8'hA5; in_amt = 3'd1; in_mode = 2'd3;
        tick;
        in_valid = 1'b0;
        tick;
        rst_n = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_valid: got %b want 0", out_valid); end
        tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL midrst_data: got %h want 00", out_data); end
        tests++; if (out_zero !== 1'b0) begin fails++; $display("FAIL midrst_zero: got %b want 0", out_zero); end
        tick;
        rst_n = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready: got %b want 1", in_ready); end
        for (int c = 0; c < 5; c++) begin
            tick;
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_stale c%0d: got %b want 0", c, out_valid); end
        end
        in_valid = 1'b1; in_data = 8'h0F; in_amt = 3'd4; in_mode = 2'd1;
        tick;
        in_valid = 1'b0;
        for (int s = 0; s < LAT; s++) begin
            tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_new_early s%0d: got %b want 0", s, out_valid); end
            tick;
        end
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL midrst_new_valid: got %b want 1", out_valid); end
        tests++; if (out_data !== 8'hF0) begin fails++; $display("FAIL midrst_new_data: got %h want f0", out_data); end
        tick;
    endtask

    initial begin
        test_reset;
        test_modes;
        test_boundaries;
        test_back_to_back;
        test_backpressure;
        test_bubbles;
        test_reset_midflight;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
